// File: rtl/desc_word_packer.sv
// rtl/desc_word_packer.sv - packs a byte-per-beat 16x16 descriptor into 32-bit words for the NCC load path
// Issue is paced by a gap counter so consecutive strobes never outrun the NCC load FSM.
module desc_word_packer #(
  parameter int PIX_W          = 8,
  parameter int WORDS_PER_DESC = 64,
  parameter int ISSUE_GAP      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               desc_start,
  input  logic               pix_valid,
  input  logic [PIX_W-1:0]   pix_in,
  output logic               pix_ready,
  output logic               desc_data_ready,
  output logic [4*PIX_W-1:0] desc_data_out,
  output logic               desc_busy,
  output logic               desc_done
);

  localparam int WORD_W    = 4 * PIX_W;
  localparam int PIX_TOTAL = 4 * WORDS_PER_DESC;
  localparam int PCNT_W    = $clog2(PIX_TOTAL + 1);
  localparam int WCNT_W    = $clog2(WORDS_PER_DESC + 1);

  localparam logic [3:0]        GAP_LOAD  = 4'(ISSUE_GAP - 1);
  localparam logic [PCNT_W-1:0] PIX_LIMIT = PCNT_W'(PIX_TOTAL);
  localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(WORDS_PER_DESC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          lane_q, lane_d;
  logic [PCNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [3:0]          gap_q, gap_d;
  logic [WORD_W-1:0]   asm_q, asm_d;
  logic                asm_full_q, asm_full_d;
  logic [WORD_W-1:0]   slot_q, slot_d;
  logic                slot_full_q, slot_full_d;
  logic                data_ready_q, data_ready_d;
  logic [WORD_W-1:0]   data_out_q, data_out_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                xfer;
  logic                issue;
  logic                issue_next;
  logic [WORD_W-1:0]   word_complete;

  assign pix_ready       = (state_q == S_LOAD) && !asm_full_q && (pix_cnt_q < PIX_LIMIT);
  assign xfer            = pix_valid && pix_ready;
  assign issue           = data_ready_q;
  assign word_complete   = {asm_q[WORD_W-1:PIX_W], pix_in};

  assign desc_data_ready = data_ready_q;
  assign desc_data_out   = data_out_q;
  assign desc_busy       = busy_q;
  assign desc_done       = done_q;

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    pix_cnt_d   = pix_cnt_q;
    word_cnt_d  = word_cnt_q;
    gap_d       = gap_q;
    asm_d       = asm_q;
    asm_full_d  = asm_full_q;
    slot_d      = slot_q;
    slot_full_d = slot_full_q;

    if (issue) begin
      slot_full_d = 1'b0;
      gap_d       = GAP_LOAD;
      word_cnt_d  = word_cnt_q + 1'b1;
      if (asm_full_q) begin
        slot_d      = asm_q;
        slot_full_d = 1'b1;
        asm_full_d  = 1'b0;
      end
    end else if (gap_q != 4'd0) begin
      gap_d = gap_q - 4'd1;
    end

    // A completed word bypasses the assembly register when the slot frees this edge.
    if (xfer) begin
      pix_cnt_d = pix_cnt_q + 1'b1;
      lane_d    = lane_q + 2'd1;
      if (lane_q == 2'd3) begin
        if (!slot_full_q || issue) begin
          slot_d      = word_complete;
          slot_full_d = 1'b1;
        end else begin
          asm_d      = word_complete;
          asm_full_d = 1'b1;
        end
      end else begin
        asm_d[(3 - int'(lane_q)) * PIX_W +: PIX_W] = pix_in;
      end
    end

    case (state_q)
      S_IDLE:  state_d = S_IDLE;
      S_LOAD:  if (issue && (word_cnt_q == WORD_LAST)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A start in any state restarts cleanly, discarding whatever was in flight.
    if (desc_start) begin
      state_d     = S_LOAD;
      lane_d      = 2'd0;
      pix_cnt_d   = '0;
      word_cnt_d  = '0;
      gap_d       = 4'd0;
      asm_full_d  = 1'b0;
      slot_full_d = 1'b0;
    end
  end

  always_comb begin
    issue_next   = (state_d == S_LOAD) && slot_full_d && (gap_d == 4'd0);
    data_ready_d = issue_next;
    data_out_d   = issue_next ? slot_d : data_out_q;
    busy_d       = (state_d == S_LOAD);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      lane_q       <= 2'd0;
      pix_cnt_q    <= '0;
      word_cnt_q   <= '0;
      gap_q        <= 4'd0;
      asm_q        <= '0;
      asm_full_q   <= 1'b0;
      slot_q       <= '0;
      slot_full_q  <= 1'b0;
      data_ready_q <= 1'b0;
      data_out_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      pix_cnt_q    <= pix_cnt_d;
      word_cnt_q   <= word_cnt_d;
      gap_q        <= gap_d;
      asm_q        <= asm_d;
      asm_full_q   <= asm_full_d;
      slot_q       <= slot_d;
      slot_full_q  <= slot_full_d;
      data_ready_q <= data_ready_d;
      data_out_q   <= data_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_desc_word_packer.sv
// tb/tb_desc_word_packer.sv - randomized bench for desc_word_packer against a pixel-queue reference model
module tb_desc_word_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start[2];
  logic        valid[2];
  logic [7:0]  pin[2];
  logic        prdy[2];
  logic        dready[2];
  logic [31:0] dout[2];
  logic        busy[2];
  logic        done[2];

  always #5 clk = ~clk;

  desc_word_packer #(.PIX_W(8), .WORDS_PER_DESC(64), .ISSUE_GAP(2)) u_dut_g2 (
    .clk(clk), .rst(rst), .desc_start(start[0]), .pix_valid(valid[0]), .pix_in(pin[0]),
    .pix_ready(prdy[0]), .desc_data_ready(dready[0]), .desc_data_out(dout[0]),
    .desc_busy(busy[0]), .desc_done(done[0])
  );

  desc_word_packer #(.PIX_W(8), .WORDS_PER_DESC(64), .ISSUE_GAP(8)) u_dut_g8 (
    .clk(clk), .rst(rst), .desc_start(start[1]), .pix_valid(valid[1]), .pix_in(pin[1]),
    .pix_ready(prdy[1]), .desc_data_ready(dready[1]), .desc_data_out(dout[1]),
    .desc_busy(busy[1]), .desc_done(done[1])
  );

  int          cyc = 0;
  int          sel = 0;
  logic [31:0] obs_w[$];
  int          obs_c[$];
  int          done_c[$];
  logic        done_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dready[sel]) begin
      obs_w.push_back(dout[sel]);
      obs_c.push_back(cyc);
    end
    if (done[sel]) begin
      done_c.push_back(cyc);
      done_b.push_back(busy[sel]);
    end
  end

  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] stim[$];
  logic [7:0] acc[$];
  int         acc_c[$];
  int         n_stall = 0;
  int         mb = 0;
  int         db = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic mark();
    mb = obs_w.size();
    db = done_c.size();
    acc.delete();
    acc_c.delete();
    stim.delete();
    n_stall = 0;
  endtask

  function automatic logic [31:0] model_word(input int k);
    if (acc.size() < 4 * k + 4) return 32'hxxxx_xxxx;
    return {acc[4*k], acc[4*k+1], acc[4*k+2], acc[4*k+3]};
  endfunction

  task automatic pulse_start(output int c);
    @(negedge clk);
    start[sel] = 1'b1;
    c = cyc;
    @(negedge clk);
    start[sel] = 1'b0;
  endtask

  task automatic drive(input int duty, input int max_cyc);
    int i = 0;
    while (stim.size() > 0 && i < max_cyc) begin
      @(negedge clk);
      i++;
      if ($urandom_range(99) < duty) begin
        valid[sel] = 1'b1;
        pin[sel]   = stim[0];
        if (prdy[sel]) begin
          acc.push_back(stim.pop_front());
          acc_c.push_back(cyc);
        end else begin
          n_stall++;
        end
      end else begin
        valid[sel] = 1'b0;
      end
    end
    @(negedge clk);
    valid[sel] = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int i = 0;
    while (done_c.size() == db && i < bound) begin
      @(negedge clk);
      i++;
    end
    chk(tag, done_c.size() > db, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_words(input string tg);
    int mism = 0;
    chk({tg, "_count"}, obs_w.size() - mb, 64);
    for (int k = 0; k < 64; k++)
      if (mb + k >= obs_w.size() || obs_w[mb + k] !== model_word(k)) mism++;
    chk({tg, "_words"}, mism, 0);
  endtask

  task automatic gap_stats(output int mn, output int mx);
    mn = 1000000;
    mx = 0;
    for (int k = mb + 1; k < obs_c.size(); k++) begin
      int d = obs_c[k] - obs_c[k-1];
      if (d < mn) mn = d;
      if (d > mx) mx = d;
    end
  endtask

  initial begin
    int c, abort_c, mn, mx, cnt, bad;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      valid[i] = 1'b0;
      pin[i]   = 8'h00;
    end
    repeat (3) @(negedge clk);
    chk("rst_ready",  dready[0], 0);
    chk("rst_dout",   dout[0],   0);
    chk("rst_busy",   busy[0],   0);
    chk("rst_done",   done[0],   0);
    chk("rst_pready", prdy[0],   0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Continuous index stream, gap 2: spacing set by the 4-beat assembly.
    sel = 0;
    mark();
    pulse_start(c);
    chk("s1_busy", busy[0], 1);
    for (int i = 0; i < 256; i++) stim.push_back(8'(i));
    drive(100, 2000);
    chk("s1_all_sent", stim.size(), 0);
    wait_done("s1_done_seen", 400);
    check_words("s1");
    chk("s1_first", (obs_w.size() > mb) ? obs_w[mb] : 32'h0, 32'h00010203);
    chk("s1_last", obs_w[obs_w.size() - 1], 32'hFCFDFEFF);
    chk("s1_latency", (obs_c.size() > mb && acc_c.size() > 3) ? obs_c[mb] : -1, acc_c[3] + 1);
    gap_stats(mn, mx);
    chk("s1_gap_min", mn, 4);
    chk("s1_gap_max", mx, 4);
    chk("s1_done_cnt", done_c.size() - db, 1);
    chk("s1_done_cyc", done_c[db], obs_c[obs_c.size() - 1] + 1);
    chk("s1_busy_at_done", done_b[db], 0);

    // Gap 8 instance: strobes paced by the gap counter, input back-pressured.
    sel = 1;
    mark();
    pulse_start(c);
    for (int i = 0; i < 256; i++) stim.push_back(8'(i));
    drive(100, 4000);
    chk("s2_all_sent", stim.size(), 0);
    wait_done("s2_done_seen", 800);
    check_words("s2");
    gap_stats(mn, mx);
    chk("s2_gap_min", mn, 8);
    chk("s2_gap_max", mx, 8);
    chk("s2_stalled", n_stall > 0, 1);
    chk("s2_done_cnt", done_c.size() - db, 1);
    repeat (3) @(negedge clk);

    // Sparse random valid at ~30% duty.
    sel = 0;
    mark();
    pulse_start(c);
    for (int i = 0; i < 256; i++) stim.push_back(8'(i));
    drive(30, 6000);
    chk("s3_all_sent", stim.size(), 0);
    wait_done("s3_done_seen", 400);
    check_words("s3");
    chk("s3_last", obs_w[obs_w.size() - 1], 32'hFCFDFEFF);
    gap_stats(mn, mx);
    chk("s3_gap_ok", mn >= 2, 1);
    chk("s3_done_cnt", done_c.size() - db, 1);

    // Abort after 37 beats, then a full descriptor of 0xA5.
    mark();
    pulse_start(c);
    for (int i = 0; i < 37; i++) stim.push_back(8'(i));
    drive(100, 200);
    pulse_start(abort_c);
    acc.delete();
    for (int i = 0; i < 256; i++) stim.push_back(8'hA5);
    drive(100, 2000);
    wait_done("s4_done_seen", 400);
    cnt = 0;
    bad = 0;
    for (int k = mb; k < obs_c.size(); k++) begin
      chk("s4_no_strobe_after_abort", obs_c[k] == abort_c + 1, 0);
      if (obs_c[k] > abort_c) begin
        cnt++;
        if (obs_w[k] !== 32'hA5A5A5A5) bad++;
      end
    end
    chk("s4_post_count", cnt, 64);
    chk("s4_post_bad", bad, 0);
    chk("s4_done_cnt", done_c.size() - db, 1);

    // 300 beats offered with valid held high: only 256 may be taken.
    mark();
    pulse_start(c);
    for (int i = 0; i < 300; i++) stim.push_back(8'($urandom));
    drive(100, 400);
    repeat (4) @(negedge clk);
    chk("s5_accepted", acc.size(), 256);
    chk("s5_leftover", stim.size(), 44);
    check_words("s5");
    chk("s5_done_cnt", done_c.size() - db, 1);
    chk("s5_idle_busy", busy[0], 0);
    chk("s5_idle_pready", prdy[0], 0);

    // Asynchronous reset mid-word, then a fresh descriptor.
    mark();
    pulse_start(c);
    for (int i = 0; i < 6; i++) stim.push_back(8'(i));
    drive(100, 50);
    chk("s6_pre_dout", dout[0], 32'h00010203);
    #2;
    rst = 1'b0;
    #1;
    chk("s6_rst_dout",   dout[0],   0);
    chk("s6_rst_ready",  dready[0], 0);
    chk("s6_rst_busy",   busy[0],   0);
    chk("s6_rst_done",   done[0],   0);
    chk("s6_rst_pready", prdy[0],   0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mark();
    pulse_start(c);
    stim.push_back(8'h11);
    stim.push_back(8'h22);
    stim.push_back(8'h33);
    stim.push_back(8'h44);
    drive(100, 50);
    for (int i = 0; i < 20 && obs_w.size() == mb; i++) @(negedge clk);
    chk("s6_strobe_seen", obs_w.size() > mb, 1);
    chk("s6_first_word", (obs_w.size() > mb) ? obs_w[mb] : 32'h0, 32'h11223344);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
